// File: rtl/dram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Package  : dram_arbiter_pkg
// Brief    : Shared constants for the DRAM arbiter: FSM state codes and the
//            bit positions inside each core's 2-bit read/write code.
// Revision : 1.0 - initial release
// ============================================================================
package dram_arbiter_pkg;

    // FSM state encoding
    localparam int               c_ST_W      = 2;
    localparam logic [c_ST_W-1:0] c_ST_IDLE   = 2'd0;
    localparam logic [c_ST_W-1:0] c_ST_ACCESS = 2'd1;
    localparam logic [c_ST_W-1:0] c_ST_RESP   = 2'd2;

    // Bit positions inside a core's read or write code
    localparam int c_REQ_BIT  = 0;
    localparam int c_LOCK_BIT = 1;

endpackage
`default_nettype wire

// File: rtl/dram_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
// Module   : dram_arbiter_rr_picker
// Brief    : Combinational round-robin picker. Returns the first requester at
//            or after the pointer, wrapping modulo NUM_CORES, as a one-hot
//            vector and as an index.
// Revision : 1.0 - initial release
// ============================================================================
module dram_arbiter_rr_picker #(
    parameter int NUM_CORES = 4,
    parameter int IDX_W     = 2
) (
    input  logic [NUM_CORES-1:0] i_req,
    input  logic [IDX_W-1:0]     i_ptr,
    output logic [NUM_CORES-1:0] o_winner_oh,
    output logic [IDX_W-1:0]     o_winner_idx,
    output logic                 o_any
);

    logic [IDX_W-1:0] w_cand;
    logic             w_found;

    // Scan candidates starting at the pointer; the first requester wins
    always_comb begin
        o_winner_oh  = '0;
        o_winner_idx = '0;
        w_found      = 1'b0;
        w_cand       = '0;
        for (int off = 0; off < NUM_CORES; off++) begin
            w_cand = IDX_W'((int'(i_ptr) + off) % NUM_CORES);
            if (!w_found && i_req[w_cand]) begin
                w_found              = 1'b1;
                o_winner_oh[w_cand]  = 1'b1;
                o_winner_idx         = w_cand;
            end
        end
    end

    assign o_any = |i_req;

endmodule
`default_nettype wire

// File: rtl/dram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dram_arbiter
// Brief    : Round-robin arbiter sharing one single-port data RAM among
//            NUM_CORES cores. One access per tenure, or a locked burst of up
//            to MAX_LOCK back-to-back accesses by the same core.
// Revision : 1.0 - initial release
// ============================================================================
module dram_arbiter
    import dram_arbiter_pkg::*;
#(
    parameter int NUM_CORES = 4,
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 8,
    parameter int MAX_LOCK  = 16
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [NUM_CORES*ADDR_W-1:0] i_core_addr,
    input  logic [NUM_CORES*2-1:0]      i_core_read,
    input  logic [NUM_CORES*2-1:0]      i_core_write,
    input  logic [NUM_CORES*DATA_W-1:0] i_core_wdata,
    output logic [NUM_CORES-1:0]        o_core_grant,
    output logic [NUM_CORES-1:0]        o_core_ack,
    output logic [DATA_W-1:0]           o_core_rdata,
    output logic [ADDR_W-1:0]           o_mem_addr,
    output logic                        o_mem_en,
    output logic                        o_mem_we,
    output logic [DATA_W-1:0]           o_mem_wdata,
    input  logic [DATA_W-1:0]           i_mem_rdata,
    output logic                        o_err
);

    localparam int IDX_W  = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int LCNT_W = $clog2(MAX_LOCK + 1);
    localparam logic [LCNT_W-1:0] c_LOCK_LAST = LCNT_W'(MAX_LOCK - 1);
    localparam logic [IDX_W-1:0]  c_IDX_LAST  = IDX_W'(NUM_CORES - 1);

    // Per-core decoded request fields
    logic [NUM_CORES-1:0] w_req;
    logic [NUM_CORES-1:0] w_wr;
    logic [NUM_CORES-1:0] w_lock;
    logic [NUM_CORES-1:0] w_both;

    // Picker results
    logic [NUM_CORES-1:0] w_pick_oh;
    logic [IDX_W-1:0]     w_pick_idx;
    logic                 w_pick_any;

    // Fields of the selected core (picker winner in IDLE, owner otherwise)
    logic [IDX_W-1:0]     w_sel_idx;
    logic [ADDR_W-1:0]    w_sel_addr;
    logic [DATA_W-1:0]    w_sel_wdata;
    logic                 w_sel_we;
    logic                 w_sel_lock;
    logic                 w_sel_req;

    logic [c_ST_W-1:0]    r_state;
    logic [c_ST_W-1:0]    w_state_nxt;
    logic                 w_continue;

    logic [IDX_W-1:0]     r_ptr;
    logic [IDX_W-1:0]     r_win_idx;
    logic [NUM_CORES-1:0] r_grant;
    logic [LCNT_W-1:0]    r_lock_cnt;
    logic [ADDR_W-1:0]    r_addr;
    logic                 r_we;
    logic [DATA_W-1:0]    r_wdata;
    logic                 r_err;

    // A write request wins when a core raises both; its lock bit follows it
    generate
        for (genvar k = 0; k < NUM_CORES; k++) begin : g_core
            assign w_wr[k]   = i_core_write[2*k + c_REQ_BIT];
            assign w_req[k]  = i_core_read[2*k + c_REQ_BIT] | w_wr[k];
            assign w_both[k] = i_core_read[2*k + c_REQ_BIT] & w_wr[k];
            assign w_lock[k] = w_wr[k] ? i_core_write[2*k + c_LOCK_BIT]
                                       : i_core_read[2*k + c_LOCK_BIT];
        end
    endgenerate

    dram_arbiter_rr_picker #(
        .NUM_CORES (NUM_CORES),
        .IDX_W     (IDX_W)
    ) u_picker (
        .i_req        (w_req),
        .i_ptr        (r_ptr),
        .o_winner_oh  (w_pick_oh),
        .o_winner_idx (w_pick_idx),
        .o_any        (w_pick_any)
    );

    assign w_sel_idx = (r_state == c_ST_IDLE) ? w_pick_idx : r_win_idx;

    // Select the addressed core's fields
    always_comb begin
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        w_sel_we    = 1'b0;
        w_sel_lock  = 1'b0;
        w_sel_req   = 1'b0;
        for (int k = 0; k < NUM_CORES; k++) begin
            if (w_sel_idx == IDX_W'(k)) begin
                w_sel_addr  = i_core_addr[k*ADDR_W +: ADDR_W];
                w_sel_wdata = i_core_wdata[k*DATA_W +: DATA_W];
                w_sel_we    = w_wr[k];
                w_sel_lock  = w_lock[k];
                w_sel_req   = w_req[k];
            end
        end
    end

    // Burst continues while the owner still requests locked and has budget left
    assign w_continue = (r_state == c_ST_RESP) && w_sel_req && w_sel_lock &&
                        (r_lock_cnt < c_LOCK_LAST);

    // Next-state decode
    always_comb begin
        w_state_nxt = c_ST_IDLE;
        case (r_state)
            c_ST_IDLE:   w_state_nxt = w_pick_any ? c_ST_ACCESS : c_ST_IDLE;
            c_ST_ACCESS: w_state_nxt = c_ST_RESP;
            c_ST_RESP:   w_state_nxt = w_continue ? c_ST_ACCESS : c_ST_IDLE;
            default:     w_state_nxt = c_ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= c_ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Tenure bookkeeping: latch the access, track burst length, advance pointer
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ptr      <= '0;
            r_win_idx  <= '0;
            r_grant    <= '0;
            r_lock_cnt <= '0;
            r_addr     <= '0;
            r_we       <= 1'b0;
            r_wdata    <= '0;
            r_err      <= 1'b0;
        end else begin
            r_err <= r_err | (|w_both);
            case (r_state)
                c_ST_IDLE: begin
                    if (w_pick_any) begin
                        r_win_idx  <= w_pick_idx;
                        r_grant    <= w_pick_oh;
                        r_lock_cnt <= '0;
                        r_addr     <= w_sel_addr;
                        r_we       <= w_sel_we;
                        r_wdata    <= w_sel_wdata;
                    end
                end
                c_ST_RESP: begin
                    if (w_continue) begin
                        r_lock_cnt <= r_lock_cnt + LCNT_W'(1);
                        r_addr     <= w_sel_addr;
                        r_we       <= w_sel_we;
                        r_wdata    <= w_sel_wdata;
                    end else begin
                        r_ptr      <= (r_win_idx == c_IDX_LAST) ? '0 : r_win_idx + IDX_W'(1);
                        r_lock_cnt <= '0;
                        r_grant    <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Enable and ack decode straight from state so a reset drops them at once
    assign o_mem_en     = (r_state == c_ST_ACCESS);
    assign o_mem_we     = r_we;
    assign o_mem_addr   = r_addr;
    assign o_mem_wdata  = r_wdata;
    assign o_core_grant = r_grant;
    assign o_core_ack   = (r_state == c_ST_RESP) ? r_grant : '0;
    assign o_core_rdata = (r_state == c_ST_RESP) ? i_mem_rdata : '0;
    assign o_err        = r_err;

endmodule
`default_nettype wire
